mini_core_cr_ctrl: RTL and testbench
====================================

// Module: mini_core_cr_ctrl
// PURPOSE
//  Parametrised control-register (CR) block for the mini_core CR window. It supersedes fixed SEG7/LED/button/switch/cursor CRs.
//  Generalised channel counts and widths. Adds input synchronisers, per-button debounce, sticky W1C press events and a maskable IRQ.
//  Sits on the core data-memory port behind the CR region decode. It drives board I/O (7-seg, LEDs, VGA cursor).
// PARAMETERS
//  CR_BASE        'h7000  byte address of register 0 (CR_MEM_REGION_FLOOR)
//  CR_SIZE        'h1000  window size in bytes; only [CR_BASE, CR_BASE+CR_SIZE) is claimed
//  N_SEG7         6       number of 8-bit seven-segment registers
//  LED_W          10      LED register width (1..32)
//  N_BTN          2       number of push-buttons (1..32)
//  SW_W           10      switch width (1..32)
//  DEBOUNCE_CYC   16'd50000  consecutive stable cycles before a button state change is accepted (>=1)
//  BTN_ACTIVE_LOW 1       1: Button_In low = pressed
// PORTS
//  Clk        in   1            core clock
//  Rst_N      in   1            asynchronous, active-low reset
//  Rd_En      in   1            read request
//  Wr_En      in   1            write request
//  Address    in   32           byte address, word aligned (bits[1:0] ignored)
//  Wr_Data    in   32           write data
//  Byte_En    in   4            write byte enables
//  Rd_Data    out  32           read data, registered
//  Rd_Valid   out  1            Rd_Data valid
//  Button_In  in   N_BTN        raw asynchronous buttons
//  Switch_In  in   SW_W         raw asynchronous switches
//  Seg7_Out   out  N_SEG7*8     SEG7 registers, reg i at [8i+7:8i]
//  Led_Out    out  LED_W        LED register
//  Cursor_H   out  32           cursor-H register
//  Cursor_V   out  32           cursor-V register
//  Irq        out  1            level interrupt, registered
// BEHAVIOUR
//  Register index idx = (Address-CR_BASE)>>2. Map:
//   - 0..N_SEG7-1: SEG7 (RW, 8b)
//   - N_SEG7: LED (RW)
//   - +1: BTN_STATE (RO)
//   - +2: BTN_EVENT (RW1C)
//   - +3: BTN_MASK (RW)
//   - +4: SWITCH (RO)
//   - +5: CURSOR_H (RW, 32b)
//   - +6: CURSOR_V (RW, 32b)
//  Fields are right-aligned; unused read bits are 0.
//  Reset: all outputs and registers are 0, Rd_Valid=0, Irq=0. Debounced state = not pressed, counters=0, sync flops=inactive level.
//  Read: Rd_En with in-window Address -> Rd_Data/Rd_Valid in the next cycle (1-cycle latency). Rd_Valid is high for one cycle per request.
//   - Out-of-window read: Rd_Valid stays 0, Rd_Data holds.
//   - In-window, unmapped idx: Rd_Valid=1, Rd_Data=0.
//  Write: Wr_En with in-window Address updates at the clock edge, per byte lane where Byte_En=1. Bits beyond the field width are dropped.
//   - Writes to RO regs or unmapped idx are ignored.
//   - BTN_EVENT: each written 1 (in enabled lanes) clears that bit.
//  Rd_En and Wr_En in the same cycle to the same idx: read returns the pre-write value.
//  Inputs: each Button_In/Switch_In bit passes a 2-flop synchroniser. Active-low buttons are inverted after sync.
//   - SWITCH reads the synced value (2-cycle input latency).
//  Debounce per button: counter increments while synced != stable, and clears to 0 when they are equal.
//   - Stable flips when the counter reaches DEBOUNCE_CYC-1 and the input still differs; the counter then clears.
//   - A glitch shorter than DEBOUNCE_CYC never changes the stable state.
//  Event: a stable 0->1 transition sets BTN_EVENT[b] (sticky). Release sets nothing.
//   - Set and W1C clear on the same bit in the same cycle: set wins (no lost press).
//  Irq <= |(BTN_EVENT & BTN_MASK), 1 cycle after the event/mask register update.
//  Rst_N assertion mid-debounce or mid-read: immediate return to reset values; a pending Rd_Valid is dropped.
// STRUCTURE
//  mini_core_pkg gets CR index localparams (CR_IDX_SEG7_0, CR_IDX_LED, ...) as functions of N_SEG7.
//  mini_core_pkg also gets the t_cr_ro/t_cr_rw structs regenerated from these parameters.
//  Sub-module mini_core_cr_debounce: sync + counter + stable + rise pulse for one button, instanced N_BTN times via generate.
// TESTING
//  1. Reset then read every idx 0..N_SEG7+6 -> all Rd_Data=0, Rd_Valid exactly 1 cycle after each Rd_En.
//  2. Write CR_BASE+4*N_SEG7 (LED) data 32'hFFFF_FFFF, Byte_En=4'b0001 -> Led_Out=10'h0FF; read back 32'h0000_00FF.
//  3. DEBOUNCE_CYC=4, Button_In[0] pressed for 3 cycles -> BTN_STATE stays 0, no event.
//     Held for 10 cycles -> BTN_STATE[0]=1, BTN_EVENT[0]=1.
//  4. BTN_MASK=1, event[0] set -> Irq=1. W1C 32'h1 -> event 0, then Irq=0 the next cycle.
//     Retest with a new press edge in the same cycle as the W1C -> event stays 1.
//  5. Rd_En+Wr_En same cycle to CURSOR_H (old 32'h12, new 32'h34) -> Rd_Data=32'h12; next read 32'h34.
//  6. Read at CR_BASE+CR_SIZE -> no Rd_Valid. Write to SWITCH -> ignored. Assert Rst_N mid-debounce -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mini_core_pkg.sv
// ---------------------------------------------------------------------------
// mini_core_pkg
// Shared definitions for the mini_core control-register window:
//   - CR register index helpers, all derived from the SEG7 register count
//   - zero-extended read views of the RO / RW registers (t_cr_ro / t_cr_rw)
//   - byte-enable to bit-mask expansion used by every writable register
// ---------------------------------------------------------------------------
package mini_core_pkg;

    // Word index inside the CR window: byte offset >> 2.
    typedef logic [29:0] cr_idx_t;

    function automatic cr_idx_t cr_idx_seg7_0();
        return cr_idx_t'(0);
    endfunction

    function automatic cr_idx_t cr_idx_led(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7);
    endfunction

    function automatic cr_idx_t cr_idx_btn_state(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7 + 1);
    endfunction

    function automatic cr_idx_t cr_idx_btn_event(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7 + 2);
    endfunction

    function automatic cr_idx_t cr_idx_btn_mask(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7 + 3);
    endfunction

    function automatic cr_idx_t cr_idx_sw(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7 + 4);
    endfunction

    function automatic cr_idx_t cr_idx_cursor_h(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7 + 5);
    endfunction

    function automatic cr_idx_t cr_idx_cursor_v(input int unsigned n_seg7);
        return cr_idx_t'(n_seg7 + 6);
    endfunction

    // Read-side views: every field is right-aligned and zero-extended.
    typedef struct packed {
        logic [31:0] btn_state;
        logic [31:0] sw;
    } t_cr_ro;

    typedef struct packed {
        logic [31:0] led;
        logic [31:0] btn_event;
        logic [31:0] btn_mask;
        logic [31:0] cursor_h;
        logic [31:0] cursor_v;
    } t_cr_rw;

    // Expand 4 byte enables into a 32-bit lane mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mini_core_cr_ctrl_if.sv
// ---------------------------------------------------------------------------
// mini_core_cr_ctrl_if
// Data-memory port of the CR window.
//   Rd_En / Wr_En : access requests        Address : byte address
//   Wr_Data       : write data             Byte_En : write byte enables
//   Rd_Data       : registered read data   Rd_Valid: one-cycle read strobe
// master = core side, slave = CR block.
// ---------------------------------------------------------------------------
interface mini_core_cr_ctrl_if;
    logic        Rd_En;
    logic        Wr_En;
    logic [31:0] Address;
    logic [31:0] Wr_Data;
    logic [3:0]  Byte_En;
    logic [31:0] Rd_Data;
    logic        Rd_Valid;

    modport master (
        output Rd_En, Wr_En, Address, Wr_Data, Byte_En,
        input  Rd_Data, Rd_Valid
    );

    modport slave (
        input  Rd_En, Wr_En, Address, Wr_Data, Byte_En,
        output Rd_Data, Rd_Valid
    );
endinterface

// File: rtl/mini_core_cr_debounce.sv
// ---------------------------------------------------------------------------
// mini_core_cr_debounce
// One push-button: 2-flop synchroniser, polarity fix, debounce counter,
// debounced state and a one-cycle rise pulse on an accepted press.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_in     : raw asynchronous button level
//   stable     : debounced pressed state (1 = pressed)
//   rise       : high in the cycle the debounced state flips 0 -> 1
// ---------------------------------------------------------------------------
module mini_core_cr_debounce #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic stable,
    output logic rise
);
    // Synchroniser flops come out of reset at the released level.
    localparam logic        IDLE_LVL = ACTIVE_LOW;
    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYC - 16'd1;

    logic        meta_q, meta_d;
    logic        sync_q, sync_d;
    logic        stable_q, stable_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pressed;

    assign pressed = sync_q ^ IDLE_LVL;

    always_comb begin
        meta_d   = btn_in;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise     = 1'b0;
        // The counter only runs while the input disagrees with the accepted
        // state; any agreeing cycle restarts the qualification window.
        if (pressed != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = pressed;
                rise     = pressed;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= IDLE_LVL;
            sync_q   <= IDLE_LVL;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
endmodule

// File: rtl/mini_core_cr_ctrl.sv
// ---------------------------------------------------------------------------
// mini_core_cr_ctrl
// Control-register window of mini_core: SEG7, LED, button state/event/mask,
// switches and VGA cursor registers behind a byte-addressed memory port.
//   Clk, Rst_N : clock, asynchronous active-low reset
//   bus        : CR data-memory port (slave side)
//   Button_In  : raw buttons           Switch_In : raw switches
//   Seg7_Out   : SEG7 regs, reg i at [8i+7:8i]
//   Led_Out    : LED register          Cursor_H/V: cursor registers
//   Irq        : registered level IRQ = |(BTN_EVENT & BTN_MASK)
// ---------------------------------------------------------------------------
module mini_core_cr_ctrl
    import mini_core_pkg::*;
#(
    parameter logic [31:0] CR_BASE        = 32'h7000,
    parameter logic [31:0] CR_SIZE        = 32'h1000,
    parameter int unsigned N_SEG7         = 6,
    parameter int unsigned LED_W          = 10,
    parameter int unsigned N_BTN          = 2,
    parameter int unsigned SW_W           = 10,
    parameter logic [15:0] DEBOUNCE_CYC   = 16'd50000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst_N,
    mini_core_cr_ctrl_if.slave  bus,
    input  logic [N_BTN-1:0]    Button_In,
    input  logic [SW_W-1:0]     Switch_In,
    output logic [N_SEG7*8-1:0] Seg7_Out,
    output logic [LED_W-1:0]    Led_Out,
    output logic [31:0]         Cursor_H,
    output logic [31:0]         Cursor_V,
    output logic                Irq
);
    localparam cr_idx_t IDX_LED       = cr_idx_led(N_SEG7);
    localparam cr_idx_t IDX_BTN_STATE = cr_idx_btn_state(N_SEG7);
    localparam cr_idx_t IDX_BTN_EVENT = cr_idx_btn_event(N_SEG7);
    localparam cr_idx_t IDX_BTN_MASK  = cr_idx_btn_mask(N_SEG7);
    localparam cr_idx_t IDX_SW        = cr_idx_sw(N_SEG7);
    localparam cr_idx_t IDX_CURSOR_H  = cr_idx_cursor_h(N_SEG7);
    localparam cr_idx_t IDX_CURSOR_V  = cr_idx_cursor_v(N_SEG7);

    logic [31:0] offset, lane_mask, rd_word;
    logic        in_win, rd_hit, wr_hit;
    cr_idx_t     idx;
    logic        addr_lsb_unused;

    // Offset compare avoids overflow of CR_BASE + CR_SIZE.
    assign offset          = bus.Address - CR_BASE;
    assign in_win          = (bus.Address >= CR_BASE) && (offset < CR_SIZE);
    assign idx             = offset[31:2];
    assign addr_lsb_unused = ^offset[1:0];
    assign lane_mask       = be_to_mask(bus.Byte_En);
    assign rd_hit          = bus.Rd_En && in_win;
    assign wr_hit          = bus.Wr_En && in_win;

    // ---------------- SEG7 registers ----------------
    for (genvar gi = 0; gi < N_SEG7; gi++) begin : g_seg7
        logic [7:0] seg_q, seg_d;
        always_comb begin
            seg_d = seg_q;
            if (wr_hit && (idx == cr_idx_t'(gi))) begin
                seg_d = (seg_q & ~lane_mask[7:0]) | (bus.Wr_Data[7:0] & lane_mask[7:0]);
            end
        end
        always_ff @(posedge Clk or negedge Rst_N) begin
            if (!Rst_N) seg_q <= '0;
            else        seg_q <= seg_d;
        end
        assign Seg7_Out[8*gi +: 8] = seg_q;
    end

    // ---------------- Buttons ----------------
    logic [N_BTN-1:0] btn_stable, btn_rise;
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        mini_core_cr_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .ACTIVE_LOW   (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clk    (Clk),
            .rst_n  (Rst_N),
            .btn_in (Button_In[gi]),
            .stable (btn_stable[gi]),
            .rise   (btn_rise[gi])
        );
    end

    // ---------------- Scalar registers ----------------
    logic [LED_W-1:0] led_q, led_d;
    logic [N_BTN-1:0] event_q, event_d, mask_q, mask_d, ev_clr;
    logic [31:0]      cursor_h_q, cursor_h_d, cursor_v_q, cursor_v_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d, irq_q, irq_d;
    t_cr_ro           ro_view;
    t_cr_rw           rw_view;

    always_comb begin
        sw_meta_d  = Switch_In;
        sw_sync_d  = sw_meta_q;
        led_d      = led_q;
        mask_d     = mask_q;
        cursor_h_d = cursor_h_q;
        cursor_v_d = cursor_v_q;
        ev_clr     = '0;
        if (wr_hit) begin
            case (idx)
                IDX_LED:       led_d  = (led_q & ~lane_mask[LED_W-1:0])
                                      | (bus.Wr_Data[LED_W-1:0] & lane_mask[LED_W-1:0]);
                IDX_BTN_EVENT: ev_clr = bus.Wr_Data[N_BTN-1:0] & lane_mask[N_BTN-1:0];
                IDX_BTN_MASK:  mask_d = (mask_q & ~lane_mask[N_BTN-1:0])
                                      | (bus.Wr_Data[N_BTN-1:0] & lane_mask[N_BTN-1:0]);
                IDX_CURSOR_H:  cursor_h_d = (cursor_h_q & ~lane_mask) | (bus.Wr_Data & lane_mask);
                IDX_CURSOR_V:  cursor_v_d = (cursor_v_q & ~lane_mask) | (bus.Wr_Data & lane_mask);
                default: ;
            endcase
        end
        // Set after clear: a press landing on a W1C of the same bit survives.
        event_d = (event_q & ~ev_clr) | btn_rise;
        irq_d   = |(event_q & mask_q);
    end

    // ---------------- Read path (values before this cycle's write) ----------------
    always_comb begin
        ro_view.btn_state = 32'(btn_stable);
        ro_view.sw        = 32'(sw_sync_q);
        rw_view.led       = 32'(led_q);
        rw_view.btn_event = 32'(event_q);
        rw_view.btn_mask  = 32'(mask_q);
        rw_view.cursor_h  = cursor_h_q;
        rw_view.cursor_v  = cursor_v_q;

        rd_word = '0;
        for (int i = 0; i < N_SEG7; i++) begin
            if (idx == cr_idx_t'(i)) rd_word = {24'd0, Seg7_Out[8*i +: 8]};
        end
        case (idx)
            IDX_LED:       rd_word = rw_view.led;
            IDX_BTN_STATE: rd_word = ro_view.btn_state;
            IDX_BTN_EVENT: rd_word = rw_view.btn_event;
            IDX_BTN_MASK:  rd_word = rw_view.btn_mask;
            IDX_SW:        rd_word = ro_view.sw;
            IDX_CURSOR_H:  rd_word = rw_view.cursor_h;
            IDX_CURSOR_V:  rd_word = rw_view.cursor_v;
            default: ;
        endcase

        rd_valid_d = rd_hit;
        rd_data_d  = rd_hit ? rd_word : rd_data_q;
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            led_q      <= '0;
            event_q    <= '0;
            mask_q     <= '0;
            cursor_h_q <= '0;
            cursor_v_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            led_q      <= led_d;
            event_q    <= event_d;
            mask_q     <= mask_d;
            cursor_h_q <= cursor_h_d;
            cursor_v_q <= cursor_v_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.Rd_Data  = rd_data_q;
    assign bus.Rd_Valid = rd_valid_q;
    assign Led_Out      = led_q;
    assign Cursor_H     = cursor_h_q;
    assign Cursor_V     = cursor_v_q;
    assign Irq          = irq_q;
endmodule

// File: tb/tb_mini_core_cr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mini_core_cr_ctrl
// Directed + randomized bench for mini_core_cr_ctrl with a reference model
// of the register map, synchronisers and debounce rules. Read responses are
// queued at issue time and checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_mini_core_cr_ctrl;
    localparam int N_SEG7 = 6;
    localparam int LED_W  = 10;
    localparam int N_BTN  = 2;
    localparam int SW_W   = 10;
    localparam int DEB    = 4;
    localparam logic [31:0] BASE = 32'h7000;
    localparam logic [31:0] SIZE = 32'h1000;
    localparam int I_LED = N_SEG7,     I_BST = N_SEG7 + 1, I_BEV = N_SEG7 + 2;
    localparam int I_BMASK = N_SEG7 + 3, I_SW = N_SEG7 + 4;
    localparam int I_CH = N_SEG7 + 5,  I_CV = N_SEG7 + 6;

    logic                Clk = 1'b0;
    logic                Rst_N = 1'b0;
    logic [N_BTN-1:0]    Button_In;
    logic [SW_W-1:0]     Switch_In;
    logic [N_SEG7*8-1:0] Seg7_Out;
    logic [LED_W-1:0]    Led_Out;
    logic [31:0]         Cursor_H, Cursor_V;
    logic                Irq;

    mini_core_cr_ctrl_if bus_if();

    mini_core_cr_ctrl #(
        .CR_BASE(BASE), .CR_SIZE(SIZE), .N_SEG7(N_SEG7), .LED_W(LED_W),
        .N_BTN(N_BTN), .SW_W(SW_W), .DEBOUNCE_CYC(16'(DEB)), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk(Clk), .Rst_N(Rst_N), .bus(bus_if.slave),
        .Button_In(Button_In), .Switch_In(Switch_In),
        .Seg7_Out(Seg7_Out), .Led_Out(Led_Out),
        .Cursor_H(Cursor_H), .Cursor_V(Cursor_V), .Irq(Irq)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- Scoreboard ----------------
    typedef struct { int due; logic [31:0] data; int idx; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] last_rd = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst_N) begin
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_lost idx%0d", e.idx), 64'(0), 64'(1));
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_valid idx%0d", e.idx), 64'(bus_if.Rd_Valid), 64'(1));
                    check($sformatf("rd_data idx%0d", e.idx), 64'(bus_if.Rd_Data), 64'(e.data));
                    last_rd = e.data;
                end else begin
                    check("rd_valid_idle", 64'(bus_if.Rd_Valid), 64'(0));
                    check("rd_data_hold", 64'(bus_if.Rd_Data), 64'(last_rd));
                end
            end
        end
    end

    // ---------------- Reference model ----------------
    logic [7:0]       m_seg [N_SEG7];
    logic [31:0]      m_led, m_ch, m_cv;
    logic [N_BTN-1:0] m_ev, m_mask, m_stable;
    int               m_run [N_BTN];
    logic [N_BTN-1:0] m_btn_h1, m_btn_h2;   // pressed level 1 / 2 cycles ago
    logic [SW_W-1:0]  m_sw_h1, m_sw_h2;
    logic             m_irq;
    logic [N_BTN-1:0] btn_press;            // current pressed level driven
    logic [SW_W-1:0]  sw_raw;

    function automatic void model_reset();
        foreach (m_seg[i]) m_seg[i] = '0;
        foreach (m_run[i]) m_run[i] = 0;
        m_led = '0; m_ch = '0; m_cv = '0;
        m_ev = '0; m_mask = '0; m_stable = '0;
        m_btn_h1 = '0; m_btn_h2 = '0; m_sw_h1 = '0; m_sw_h2 = '0;
        m_irq = 1'b0;
    endfunction

    function automatic logic [31:0] lane_mask_f(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx < N_SEG7)    return 32'(m_seg[idx]);
        if (idx == I_LED)    return m_led;
        if (idx == I_BST)    return 32'(m_stable);
        if (idx == I_BEV)    return 32'(m_ev);
        if (idx == I_BMASK)  return 32'(m_mask);
        if (idx == I_SW)     return 32'(m_sw_h2);
        if (idx == I_CH)     return m_ch;
        if (idx == I_CV)     return m_cv;
        return 32'h0;
    endfunction

    // True when this coming edge is the DEB-th consecutive pressed sample.
    function automatic bit will_rise(input int b);
        return (m_btn_h2[b] == 1'b1) && (m_stable[b] == 1'b0) && (m_run[b] + 1 == DEB);
    endfunction

    // One bus cycle: drive, predict, clock, check board outputs.
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        logic             in_win, irq_n;
        int               idx;
        logic [31:0]      lm, merged, clr;
        logic [N_BTN-1:0] rise;
        logic [N_SEG7*8-1:0] exp_seg;

        bus_if.Rd_En = rd; bus_if.Wr_En = wr; bus_if.Address = addr;
        bus_if.Wr_Data = wdata; bus_if.Byte_En = be;
        Button_In = ~btn_press;
        Switch_In = sw_raw;

        in_win = (addr >= BASE) && ((addr - BASE) < SIZE);
        idx    = in_win ? int'((addr - BASE) >> 2) : -1;
        lm     = lane_mask_f(be);
        clr    = '0;
        if (rd && in_win) exp_q.push_back('{cyc + 1, model_read(idx), idx});

        rise = '0;
        for (int b = 0; b < N_BTN; b++) begin
            if (m_btn_h2[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_stable[b] = m_btn_h2[b];
                    m_run[b]    = 0;
                    rise[b]     = m_stable[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end

        irq_n = |(m_ev & m_mask);
        if (wr && in_win) begin
            if (idx < N_SEG7) begin
                merged = (32'(m_seg[idx]) & ~lm) | (wdata & lm);
                m_seg[idx] = merged[7:0];
            end else if (idx == I_LED) begin
                m_led = ((m_led & ~lm) | (wdata & lm)) & ((32'h1 << LED_W) - 1);
            end else if (idx == I_BEV) begin
                clr = wdata & lm;
            end else if (idx == I_BMASK) begin
                merged = (32'(m_mask) & ~lm) | (wdata & lm);
                m_mask = merged[N_BTN-1:0];
            end else if (idx == I_CH) begin
                m_ch = (m_ch & ~lm) | (wdata & lm);
            end else if (idx == I_CV) begin
                m_cv = (m_cv & ~lm) | (wdata & lm);
            end
        end
        m_ev  = (m_ev & ~clr[N_BTN-1:0]) | rise;
        m_irq = irq_n;
        m_btn_h2 = m_btn_h1; m_btn_h1 = btn_press;
        m_sw_h2  = m_sw_h1;  m_sw_h1  = sw_raw;

        @(posedge Clk); #1;
        for (int i = 0; i < N_SEG7; i++) exp_seg[8*i +: 8] = m_seg[i];
        check("seg7_out", 64'(Seg7_Out), 64'(exp_seg));
        check("led_out", 64'(Led_Out), 64'(m_led));
        check("cursor_h", 64'(Cursor_H), 64'(m_ch));
        check("cursor_v", 64'(Cursor_V), 64'(m_cv));
        check("irq", 64'(Irq), 64'(m_irq));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd(input int idx);
        step(1'b1, 1'b0, BASE + 32'(4 * idx), 32'h0, 4'h0);
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, BASE + 32'(4 * idx), d, be);
    endtask

    // Asserts reset at the current time, checks outputs cleared with no
    // clock edge, then releases just after a rising edge.
    task automatic apply_reset();
        Rst_N = 1'b0;
        exp_q.delete();
        last_rd   = '0;
        btn_press = '0;
        sw_raw    = '0;
        model_reset();
        Button_In = ~btn_press;
        Switch_In = sw_raw;
        bus_if.Rd_En = 1'b0; bus_if.Wr_En = 1'b0; bus_if.Address = '0;
        bus_if.Wr_Data = '0; bus_if.Byte_En = '0;
        #1;
        check("rst_rd_valid", 64'(bus_if.Rd_Valid), 64'(0));
        check("rst_rd_data", 64'(bus_if.Rd_Data), 64'(0));
        check("rst_seg7", 64'(Seg7_Out), 64'(0));
        check("rst_led", 64'(Led_Out), 64'(0));
        check("rst_cursor_h", 64'(Cursor_H), 64'(0));
        check("rst_cursor_v", 64'(Cursor_V), 64'(0));
        check("rst_irq", 64'(Irq), 64'(0));
        repeat (3) @(posedge Clk);
        #1;
        Rst_N = 1'b1;
    endtask

    initial begin
        bit found;
        int r;
        logic [31:0] addr;

        #1;
        apply_reset();

        // Every register reads 0 after reset, plus one unmapped index.
        for (int i = 0; i <= N_SEG7 + 6; i++) rd(i);
        rd(N_SEG7 + 7);
        idle();

        // LED byte-lane write, bits beyond the field dropped.
        wr(I_LED, 32'hFFFF_FFFF, 4'b0001);
        rd(I_LED);
        idle();

        // Short glitch on button 0, then a real press.
        btn_press = 2'b01;
        repeat (3) idle();
        btn_press = 2'b00;
        repeat (8) idle();
        rd(I_BST); rd(I_BEV);
        btn_press = 2'b01;
        repeat (10) idle();
        rd(I_BST); rd(I_BEV);

        // IRQ via mask, W1C clear, then W1C colliding with a new press.
        wr(I_BMASK, 32'h1, 4'b0001);
        repeat (2) idle();
        wr(I_BEV, 32'h1, 4'b0001);
        repeat (2) idle();
        rd(I_BEV);
        btn_press = 2'b00;
        repeat (10) idle();
        btn_press = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (will_rise(0)) begin
                wr(I_BEV, 32'h1, 4'b0001);
                found = 1'b1;
            end else begin
                idle();
            end
        end
        if (!found) begin
            n_cmp++; n_bad++;
            $display("FAIL press_edge_timeout: got none, expected rise within 20 cycles");
        end
        rd(I_BEV);
        repeat (2) idle();

        // Read and write of CURSOR_H in the same cycle.
        wr(I_CH, 32'h12, 4'hF);
        step(1'b1, 1'b1, BASE + 32'(4 * I_CH), 32'h34, 4'hF);
        rd(I_CH);

        // Window edges, RO write, unmapped reads, switch readback.
        step(1'b1, 1'b0, BASE + SIZE, 32'h0, 4'h0);
        step(1'b1, 1'b0, BASE - 32'h4, 32'h0, 4'h0);
        sw_raw = 10'h2A5;
        repeat (3) idle();
        wr(I_SW, 32'hFFFF_FFFF, 4'hF);
        rd(I_SW);
        rd(N_SEG7 + 200);
        idle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       addr = BASE + 32'(4 * $urandom_range(0, 14)) + 32'($urandom_range(0, 3));
            else if (r == 8) addr = BASE + SIZE + 32'(4 * $urandom_range(0, 3));
            else             addr = BASE - 32'(4 * $urandom_range(1, 4));
            sw_raw = 10'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, N_BTN - 1));
                btn_press[r] = ~btn_press[r];
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), addr,
                 $urandom, 4'($urandom));
        end
        btn_press = '0;
        repeat (2) idle();

        // Reset while a read response is on the bus.
        wr(I_CH, 32'hDEAD_BEEF, 4'hF);
        rd(I_CH);
        #2;
        apply_reset();
        rd(I_CH);
        idle();

        // Reset in the middle of a debounce.
        btn_press = 2'b11;
        repeat (4) idle();
        #2;
        apply_reset();
        repeat (4) idle();
        rd(I_BST); rd(I_BEV);
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
